sar_compare_initiator: RTL and testbench
========================================

# sar_compare_initiator

Successive-approximation search controller that drives the trial operand of an external combinational magnitude comparator and reads back its greater/equal/less flags to locate a hidden target value. It resolves the target one bit per cycle, MSB first, and terminates early on equality. The block sits on the initiating side of the comparator interface: it supplies the trial value and consumes the g/e/l result. The comparator's other operand is the target and is outside this block.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a search; sampled only in IDLE
- g  input  1  comparator: trial > target
- e  input  1  comparator: trial == target
- l  input  1  comparator: trial < target
- trial  output  WIDTH  registered trial value to the comparator x operand
- busy  output  1  high in SEARCH and CHECK
- done  output  1  one-cycle pulse when a search ends
- result  output  WIDTH  resolved value; held until the next accepted start
- found  output  1  result was confirmed equal by the comparator; held with result
- err  output  1  comparator flags were not one-hot during the search; held with result

## Operation
- Reset values: trial=0, busy=0, done=0, result=0, found=0, err=0, state=IDLE, idx=WIDTH-1.
- IDLE:
  - On start=1: trial←1<<(WIDTH-1), idx←WIDTH-1, result/found/err←0, go to SEARCH.
  - start is ignored in every other state.
- SEARCH: sample {g,e,l} against the current trial on each clock edge.
  - Not exactly one flag high: err←1, found←0, result←trial, go to DONE.
  - e: result←trial, found←1, go to DONE (early exit).
  - l, idx>0: keep bit idx, set bit idx-1, idx←idx-1.
  - g, idx>0: clear bit idx, set bit idx-1, idx←idx-1.
  - l, idx==0: result←trial, found←0, go to DONE. This case means the target is inconsistent or out of range.
  - g, idx==0: clear bit 0, go to CHECK.
- CHECK: sample flags against the final trial.
  - Not one-hot: err←1.
  - e: found←1.
  - Otherwise: found←0.
  - result←trial, go to DONE.
- DONE: done=1 for exactly this cycle, busy=0, then go to IDLE. trial holds its last value.
- Arithmetic: trial bits above idx are frozen decisions; only bits idx and idx-1 change per step. There is no carry or overflow path.

## Timing
- trial is registered. g/e/l are treated as combinational functions of trial and are sampled at the edge following trial's update.
- busy rises the cycle after start is accepted and falls in the DONE cycle.
- Latency from the accepting edge to the done pulse: k+1 cycles when e is seen on compare k (1..WIDTH). A search that reaches CHECK takes WIDTH+2 cycles, i.e. WIDTH SEARCH, 1 CHECK, then DONE.
- result/found/err are valid in the done cycle and remain stable until the next accepted start.
- start held high across DONE→IDLE begins a new search on the first IDLE edge.
- Async rst mid-search forces all outputs to their reset values immediately. No done pulse is generated.

## Test plan
- WIDTH=8, target=0x80: start → trial=0x80, e on first compare → done 2 cycles after start, result=0x80, found=1, err=0.
- Target=0xB5 with an ideal comparator model → trial sequence 0x80,0xC0,0xA0,0xB0,0xB8,0xB4,0xB6,0xB5 → result=0xB5, found=1, done 9 cycles after start.
- Target=0x00 → trials 0x80..0x01 all g, CHECK with trial=0x00 and e → result=0x00, found=1, done at cycle 10.
- Force g=e=1 on the third compare → err=1, found=0, result=0xA0 or 0xE0 per the prior decisions, done the next cycle.
- Pulse start while busy=1 → ignored; trial sequence unchanged. Hold start high → a new search begins in the IDLE cycle after done.
- Assert rst during the 4th SEARCH cycle → trial, busy, result, found, err all go to 0 asynchronously, no done pulse. The next start runs a normal search.

Source files
------------

// File: rtl/sar_compare_initiator.sv
//==============================================================================
// sar_compare_initiator -- MSB-first successive-approximation search that drives
// an external magnitude comparator and resolves the target from its g/e/l flags.
// Revision: 1.0
//==============================================================================
`default_nettype none

module sar_compare_initiator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             g,
  input  logic             e,
  input  logic             l,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int             IW      = $clog2(WIDTH);
  localparam logic [IW-1:0]  IDX_MSB = IW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       r_state, w_state;
  logic [WIDTH-1:0] r_trial, w_trial;
  logic [IW-1:0]    r_idx, w_idx;
  logic [WIDTH-1:0] r_result, w_result;
  logic             r_found, w_found;
  logic             r_err, w_err;

  logic             w_onehot;
  logic [IW-1:0]    w_idx_m1;

  // Exactly one of the three comparator flags must be asserted.
  assign w_onehot = (g ^ e ^ l) & ~(g & e & l);
  assign w_idx_m1 = r_idx - IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_trial  <= '0;
      r_idx    <= IDX_MSB;
      r_result <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_trial  <= w_trial;
      r_idx    <= w_idx;
      r_result <= w_result;
      r_found  <= w_found;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_trial  = r_trial;
    w_idx    = r_idx;
    w_result = r_result;
    w_found  = r_found;
    w_err    = r_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_trial            = '0;
          w_trial[WIDTH-1]   = 1'b1;
          w_idx              = IDX_MSB;
          w_result           = '0;
          w_found            = 1'b0;
          w_err              = 1'b0;
          w_state            = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (!w_onehot) begin
          w_err    = 1'b1;
          w_found  = 1'b0;
          w_result = r_trial;
          w_state  = S_DONE;
        end else if (e) begin
          w_found  = 1'b1;
          w_result = r_trial;
          w_state  = S_DONE;
        end else if (l) begin
          if (r_idx != '0) begin
            w_trial[w_idx_m1] = 1'b1;
            w_idx             = w_idx_m1;
          end else begin
            // Trial already all-ones below the frozen bits yet still low:
            // the target is out of range or the comparator is inconsistent.
            w_found  = 1'b0;
            w_result = r_trial;
            w_state  = S_DONE;
          end
        end else begin
          if (r_idx != '0) begin
            w_trial[r_idx]    = 1'b0;
            w_trial[w_idx_m1] = 1'b1;
            w_idx             = w_idx_m1;
          end else begin
            w_trial[0] = 1'b0;
            w_state    = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        w_err    = r_err | ~w_onehot;
        w_found  = w_onehot & e;
        w_result = r_trial;
        w_state  = S_DONE;
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == S_SEARCH) || (r_state == S_CHECK);
    done   = (r_state == S_DONE);
    trial  = r_trial;
    result = r_result;
    found  = r_found;
    err    = r_err;
  end

endmodule

`default_nettype wire

// File: tb/tb_sar_compare_initiator.sv
//==============================================================================
// tb_sar_compare_initiator -- directed bench with an ideal comparator model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_sar_compare_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cmp_g, cmp_e, cmp_l;
  logic [7:0] trial;
  logic       busy, done, found, err;
  logic [7:0] result;

  logic [7:0] target;
  logic       force_ge;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sar_compare_initiator #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .g      (cmp_g),
    .e      (cmp_e),
    .l      (cmp_l),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    cmp_g = (trial > target);
    cmp_e = (trial == target);
    cmp_l = (trial < target);
    if (force_ge) begin
      cmp_g = 1'b1;
      cmp_e = 1'b1;
      cmp_l = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accept a search, walk the expected trial sequence, then check the done cycle.
  task automatic run_search(input string name, input logic [7:0] tgt, input int n_edges,
                            input logic [7:0] seq [0:9], input logic [7:0] exp_res,
                            input logic exp_found, input int pulse_at);
    target = tgt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk({name, " busy_rise"}, busy, 1);
    for (int k = 0; k < n_edges; k++) begin
      chk($sformatf("%s trial%0d", name, k), trial, seq[k]);
      chk($sformatf("%s nodone%0d", name, k), done, 0);
      if (k == pulse_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk({name, " done"},   done,   1);
    chk({name, " busy0"},  busy,   0);
    chk({name, " result"}, result, exp_res);
    chk({name, " found"},  found,  exp_found);
    chk({name, " err"},    err,    0);
    tick();
    chk({name, " done_1cyc"}, done,   0);
    chk({name, " held"},      result, exp_res);
  endtask

  logic [7:0] seq [0:9];

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    target   = 8'h00;
    force_ge = 1'b0;
    tick();
    tick();
    chk("rst trial",  trial,  0);
    chk("rst busy",   busy,   0);
    chk("rst done",   done,   0);
    chk("rst result", result, 0);
    chk("rst found",  found,  0);
    chk("rst err",    err,    0);
    rst = 1'b0;
    tick();
    chk("idle busy", busy, 0);

    // Equality on the very first compare.
    seq = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_search("t80", 8'h80, 1, seq, 8'h80, 1'b1, -1);

    // Full-depth search; a start pulse mid-search must be ignored.
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hB8, 8'hB4, 8'hB6, 8'hB5, 8'h00, 8'h00};
    run_search("tB5", 8'hB5, 8, seq, 8'hB5, 1'b1, 3);

    // All g decisions, resolved in CHECK.
    seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'h00};
    run_search("t00", 8'h00, 9, seq, 8'h00, 1'b1, -1);

    // Non-one-hot flags on the third compare (trial 0xA0 for target 0xB5).
    target = 8'hB5;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    chk("err trial3", trial, 8'hA0);
    force_ge = 1'b1;
    tick();
    force_ge = 1'b0;
    chk("err done",   done,   1);
    chk("err flag",   err,    1);
    chk("err found",  found,  0);
    chk("err result", result, 8'hA0);

    // start held high across DONE -> IDLE restarts on the first IDLE edge.
    start = 1'b1;
    tick();
    chk("hold idle busy", busy,   0);
    chk("hold idle res",  result, 8'hA0);
    chk("hold idle err",  err,    1);
    tick();
    start = 1'b0;
    chk("hold accept busy",  busy,   1);
    chk("hold accept trial", trial,  8'h80);
    chk("hold accept res",   result, 0);
    chk("hold accept err",   err,    0);
    target = 8'h80;
    tick();
    chk("hold done",  done,   1);
    chk("hold found", found,  1);
    chk("hold res",   result, 8'h80);
    tick();

    // Asynchronous reset in the 4th SEARCH cycle.
    target = 8'hB5;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    tick();
    chk("pre-rst trial", trial, 8'hB0);
    rst = 1'b1;
    #1;
    chk("arst trial",  trial,  0);
    chk("arst busy",   busy,   0);
    chk("arst result", result, 0);
    chk("arst found",  found,  0);
    chk("arst err",    err,    0);
    chk("arst done",   done,   0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post-rst nodone%0d", k), done, 0);
    end

    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hB8, 8'hB4, 8'hB6, 8'hB5, 8'h00, 8'h00};
    run_search("rerun", 8'hB5, 8, seq, 8'hB5, 1'b1, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
